// File: rtl/inv_check_pkg.sv
// Shared constants and FSM state type for the matrix-inverse product checker.
package inv_check_pkg;

  localparam int unsigned N       = 5;
  localparam int unsigned W       = 32;
  localparam int unsigned AccW    = 2 * W + 3;
  localparam int unsigned NumElem = N * N;
  localparam int unsigned IdxW    = $clog2(N);
  localparam int unsigned CntW    = $clog2(2 * N * N);

  typedef enum logic [1:0] {
    StLoad,
    StMac,
    StOut,
    StDone
  } state_e;

endpackage

// File: rtl/mac_unit.sv
// Registered signed multiply-accumulate; clear takes priority over enable.
module mac_unit
  import inv_check_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic [W-1:0]    a_i,
  input  logic [W-1:0]    b_i,
  output logic [AccW-1:0] acc_o
);

  logic signed [2*W-1:0] prod;
  logic [AccW-1:0]       acc_d, acc_q;

  assign prod  = $signed(a_i) * $signed(b_i);
  assign acc_o = acc_q;

  // Next accumulator value: clear, accumulate the sign-extended product, or hold.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + {{(AccW - 2 * W){prod[2*W-1]}}, prod};
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/inv_product_checker.sv
// Loads A and B, streams C = A*B row-major through one MAC, and flags C == I.
module inv_product_checker
  import inv_check_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [W-1:0]    in_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [AccW-1:0] out_data_o,
  output logic            out_last_o,
  output logic            done_o,
  output logic            is_identity_o
);

  localparam logic [CntW-1:0] LastBeat = CntW'(2 * NumElem - 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(N - 1);

  state_e          state_d, state_q;
  logic [CntW-1:0] ld_cnt_d, ld_cnt_q;
  logic [IdxW-1:0] i_d, i_q, j_d, j_q, k_d, k_q;
  logic            mismatch_d, mismatch_q;
  logic            is_identity_d, is_identity_q;

  // A occupies slots 0..N*N-1, B occupies N*N..2*N*N-1, both row-major.
  logic [W-1:0]    mem_q [2*NumElem];
  logic            mem_we;
  logic [CntW-1:0] a_idx, b_idx;

  logic            mac_clr, mac_en;
  logic [AccW-1:0] mac_acc;
  logic            is_last, elem_mis;

  assign a_idx = CntW'(i_q) * CntW'(N) + CntW'(k_q);
  assign b_idx = CntW'(NumElem) + CntW'(k_q) * CntW'(N) + CntW'(j_q);

  assign is_last  = (i_q == LastIdx) && (j_q == LastIdx);
  assign elem_mis = mac_acc != {{(AccW - 1){1'b0}}, (i_q == j_q)};

  assign is_identity_o = is_identity_q;

  mac_unit u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (mem_q[a_idx]),
    .b_i   (mem_q[b_idx]),
    .acc_o (mac_acc)
  );

  // Operand storage; contents are don't-care until a full load completes.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[ld_cnt_q] <= in_data_i;
    end
  end

  // FSM next-state, counters and handshake outputs.
  always_comb begin
    state_d       = state_q;
    ld_cnt_d      = ld_cnt_q;
    i_d           = i_q;
    j_d           = j_q;
    k_d           = k_q;
    mismatch_d    = mismatch_q;
    is_identity_d = is_identity_q;
    mem_we        = 1'b0;
    mac_clr       = 1'b0;
    mac_en        = 1'b0;
    in_ready_o    = 1'b0;
    out_valid_o   = 1'b0;
    out_data_o    = '0;
    out_last_o    = 1'b0;
    done_o        = 1'b0;

    case (state_q)
      StLoad: begin
        in_ready_o = 1'b1;
        mac_clr    = 1'b1;
        if (in_valid_i) begin
          mem_we = 1'b1;
          if (ld_cnt_q == LastBeat) begin
            ld_cnt_d   = '0;
            i_d        = '0;
            j_d        = '0;
            k_d        = '0;
            mismatch_d = 1'b0;
            state_d    = StMac;
          end else begin
            ld_cnt_d = ld_cnt_q + 1'b1;
          end
        end
      end
      StMac: begin
        mac_en = 1'b1;
        if (k_q == LastIdx) begin
          k_d     = '0;
          state_d = StOut;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StOut: begin
        out_valid_o = 1'b1;
        out_data_o  = mac_acc;
        out_last_o  = is_last;
        if (out_ready_i) begin
          mac_clr    = 1'b1;
          mismatch_d = mismatch_q | elem_mis;
          k_d        = '0;
          if (is_last) begin
            // Capture the verdict here so it is already valid alongside done.
            is_identity_d = ~(mismatch_q | elem_mis);
            i_d           = '0;
            j_d           = '0;
            state_d       = StDone;
          end else begin
            if (j_q == LastIdx) begin
              j_d = '0;
              i_d = i_q + 1'b1;
            end else begin
              j_d = j_q + 1'b1;
            end
            state_d = StMac;
          end
        end
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StLoad;
      end
      default: state_d = StLoad;
    endcase
  end

  // State, counter and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StLoad;
      ld_cnt_q      <= '0;
      i_q           <= '0;
      j_q           <= '0;
      k_q           <= '0;
      mismatch_q    <= 1'b0;
      is_identity_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ld_cnt_q      <= ld_cnt_d;
      i_q           <= i_d;
      j_q           <= j_d;
      k_q           <= k_d;
      mismatch_q    <= mismatch_d;
      is_identity_q <= is_identity_d;
    end
  end

endmodule

// File: tb/tb_inv_product_checker.sv
// Scoreboard bench for inv_product_checker: model results queued at load, compared on output.
module tb_inv_product_checker;

  localparam int Dim   = 5;
  localparam int Elems = Dim * Dim;
  localparam int Spc   = Dim + 1;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [66:0] out_data;
  logic        out_last;
  logic        done;
  logic        is_identity;

  inv_product_checker dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_data_i     (in_data),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_data_o    (out_data),
    .out_last_o    (out_last),
    .done_o        (done),
    .is_identity_o (is_identity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass, n_total;

  logic signed [31:0] ma [Elems];
  logic signed [31:0] mb [Elems];
  logic signed [66:0] exp_q [$];
  logic signed [66:0] got_q [$];
  bit                 last_q [$];
  bit                 exp_ident;

  int   first_valid_cyc, spacing_err, stable_err, ready_err;
  bit   done_seen, valid_at_done;
  logic ident_after;

  task automatic set_identity();
    for (int e = 0; e < Elems; e++) begin
      ma[e] = (e % (Dim + 1) == 0) ? 32'sd1 : 32'sd0;
      mb[e] = (e % (Dim + 1) == 0) ? 32'sd1 : 32'sd0;
    end
  endtask

  // Pushes the model's C onto the scoreboard, then streams A and B in.
  task automatic load_matrices();
    logic signed [66:0] c, ea, eb;
    exp_ident = 1'b1;
    for (int r = 0; r < Dim; r++) begin
      for (int cc = 0; cc < Dim; cc++) begin
        c = 0;
        for (int k = 0; k < Dim; k++) begin
          ea = ma[r*Dim+k];
          eb = mb[k*Dim+cc];
          c  = c + ea * eb;
        end
        exp_q.push_back(c);
        if (c != ((r == cc) ? 67'sd1 : 67'sd0)) exp_ident = 1'b0;
      end
    end
    for (int b = 0; b < 2 * Elems; b++) begin
      in_valid = 1'b1;
      in_data  = (b < Elems) ? ma[b] : mb[b-Elems];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Gathers C outputs until done, optionally stalling one element or spraying input.
  task automatic collect(input int stall_elem, input int stall_cycles, input bit junk);
    int          elem, prev, stall_left;
    bit          in_stall;
    logic [66:0] held;
    got_q.delete();
    last_q.delete();
    first_valid_cyc = -1;
    spacing_err     = 0;
    stable_err      = 0;
    ready_err       = 0;
    done_seen       = 1'b0;
    valid_at_done   = 1'b0;
    ident_after     = 1'bx;
    elem            = 0;
    prev            = -1;
    stall_left      = stall_cycles;
    in_stall        = 1'b0;
    held            = '0;
    out_ready       = 1'b1;
    for (int cyc = 1; cyc <= 3000 && !done_seen; cyc++) begin
      @(negedge clk);
      if (junk) begin
        in_valid = 1'b1;
        in_data  = $urandom;
      end
      if (in_stall && !out_valid) stable_err++;
      if (done) begin
        done_seen     = 1'b1;
        valid_at_done = out_valid;
        in_valid      = 1'b0;
      end else if (out_valid) begin
        if (in_ready) ready_err++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (elem == stall_elem && stall_left > 0) begin
          if (!in_stall) held = out_data;
          else if (out_data !== held) stable_err++;
          in_stall = 1'b1;
          stall_left--;
          out_ready = 1'b0;
        end else begin
          if (in_stall && out_data !== held) stable_err++;
          in_stall = 1'b0;
          if (stall_cycles == 0 && prev >= 0 && cyc - prev != Spc) spacing_err++;
          prev = cyc;
          got_q.push_back(out_data);
          last_q.push_back(out_last);
          elem++;
          out_ready = 1'b1;
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (done_seen) begin
      @(negedge clk);
      ident_after = is_identity;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (in_ready === 1'b1) n_pass++;
    else $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    n_total++; if (out_valid === 1'b0) n_pass++;
    else $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    n_total++; if (out_data === 67'd0) n_pass++;
    else $display("FAIL reset_out_data: got %0d expected 0", out_data);
    n_total++; if (out_last === 1'b0) n_pass++;
    else $display("FAIL reset_out_last: got %b expected 0", out_last);
    n_total++; if (done === 1'b0) n_pass++;
    else $display("FAIL reset_done: got %b expected 0", done);
    n_total++; if (is_identity === 1'b0) n_pass++;
    else $display("FAIL reset_is_identity: got %b expected 0", is_identity);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_identity();
    logic signed [66:0] e;
    set_identity();
    load_matrices();
    collect(-1, 0, 1'b0);
    n_total++; if (done_seen) n_pass++;
    else $display("FAIL ident_done: got no done pulse expected one within budget");
    n_total++; if (got_q.size() == Elems) n_pass++;
    else $display("FAIL ident_count: got %0d expected %0d", got_q.size(), Elems);
    for (int x = 0; x < got_q.size() && exp_q.size() > 0; x++) begin
      e = exp_q.pop_front();
      n_total++; if (got_q[x] === e) n_pass++;
      else $display("FAIL ident_c[%0d]: got %0d expected %0d", x, $signed(got_q[x]), e);
      n_total++; if (last_q[x] === (x == Elems - 1)) n_pass++;
      else $display("FAIL ident_last[%0d]: got %b expected %b", x, last_q[x], x == Elems - 1);
    end
    exp_q.delete();
    n_total++; if (first_valid_cyc == Spc) n_pass++;
    else $display("FAIL ident_latency: got %0d expected %0d", first_valid_cyc, Spc);
    n_total++; if (spacing_err == 0) n_pass++;
    else $display("FAIL ident_spacing: got %0d bad gaps expected 0", spacing_err);
    n_total++; if (!valid_at_done) n_pass++;
    else $display("FAIL ident_valid_at_done: got 1 expected 0");
    n_total++; if (ident_after === exp_ident && exp_ident) n_pass++;
    else $display("FAIL ident_flag: got %b expected 1", ident_after);
  endtask

  task automatic test_inverse_pair();
    logic signed [66:0] e;
    set_identity();
    ma[18] = 32'sd1;  ma[19] = 32'sd4;  ma[23] = 32'sd2;  ma[24] = 32'sd9;
    mb[18] = 32'sd9;  mb[19] = -32'sd4; mb[23] = -32'sd2; mb[24] = 32'sd1;
    load_matrices();
    collect(-1, 0, 1'b0);
    n_total++; if (got_q.size() == Elems) n_pass++;
    else $display("FAIL inv_count: got %0d expected %0d", got_q.size(), Elems);
    for (int x = 0; x < got_q.size() && exp_q.size() > 0; x++) begin
      e = exp_q.pop_front();
      n_total++; if (got_q[x] === e) n_pass++;
      else $display("FAIL inv_c[%0d]: got %0d expected %0d", x, $signed(got_q[x]), e);
    end
    exp_q.delete();
    n_total++; if (ident_after === 1'b1) n_pass++;
    else $display("FAIL inv_flag: got %b expected 1", ident_after);
  endtask

  task automatic test_non_identity();
    logic signed [66:0] e;
    set_identity();
    ma[18] = 32'sd1; ma[19] = 32'sd4; ma[23] = 32'sd2; ma[24] = 32'sd9;
    load_matrices();
    // Input is sprayed while busy; none of it may be taken.
    collect(-1, 0, 1'b1);
    n_total++; if (got_q.size() == Elems) n_pass++;
    else $display("FAIL nonid_count: got %0d expected %0d", got_q.size(), Elems);
    for (int x = 0; x < got_q.size() && exp_q.size() > 0; x++) begin
      e = exp_q.pop_front();
      n_total++; if (got_q[x] === e) n_pass++;
      else $display("FAIL nonid_c[%0d]: got %0d expected %0d", x, $signed(got_q[x]), e);
    end
    exp_q.delete();
    if (got_q.size() == Elems) begin
      n_total++; if (got_q[19] === 67'sd4 && got_q[23] === 67'sd2 && got_q[24] === 67'sd9) n_pass++;
      else $display("FAIL nonid_fixed: got %0d/%0d/%0d expected 4/2/9",
                    got_q[19], got_q[23], got_q[24]);
    end
    n_total++; if (ready_err == 0) n_pass++;
    else $display("FAIL nonid_in_ready: got %0d ready cycles expected 0", ready_err);
    n_total++; if (ident_after === 1'b0) n_pass++;
    else $display("FAIL nonid_flag: got %b expected 0", ident_after);
  endtask

  task automatic test_backpressure();
    logic signed [66:0] e;
    set_identity();
    load_matrices();
    collect(7, 3, 1'b0);
    n_total++; if (stable_err == 0) n_pass++;
    else $display("FAIL bp_stable: got %0d unstable cycles expected 0", stable_err);
    n_total++; if (got_q.size() == Elems) n_pass++;
    else $display("FAIL bp_count: got %0d expected %0d", got_q.size(), Elems);
    for (int x = 0; x < got_q.size() && exp_q.size() > 0; x++) begin
      e = exp_q.pop_front();
      n_total++; if (got_q[x] === e) n_pass++;
      else $display("FAIL bp_c[%0d]: got %0d expected %0d", x, $signed(got_q[x]), e);
    end
    exp_q.delete();
    n_total++; if (ident_after === 1'b1) n_pass++;
    else $display("FAIL bp_flag: got %b expected 1", ident_after);
  endtask

  task automatic test_reset_mid_op();
    logic signed [66:0] e;
    int seen;
    set_identity();
    load_matrices();
    seen = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 500 && seen < 12; cyc++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_total++; if (seen == 12) n_pass++;
    else $display("FAIL mid_reach: got %0d outputs expected 12", seen);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    n_total++; if (in_ready === 1'b1) n_pass++;
    else $display("FAIL mid_in_ready: got %b expected 1", in_ready);
    n_total++; if (out_valid === 1'b0) n_pass++;
    else $display("FAIL mid_out_valid: got %b expected 0", out_valid);
    n_total++; if (is_identity === 1'b0) n_pass++;
    else $display("FAIL mid_is_identity: got %b expected 0", is_identity);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    load_matrices();
    collect(-1, 0, 1'b0);
    n_total++; if (got_q.size() == Elems) n_pass++;
    else $display("FAIL mid_count: got %0d expected %0d", got_q.size(), Elems);
    for (int x = 0; x < got_q.size() && exp_q.size() > 0; x++) begin
      e = exp_q.pop_front();
      n_total++; if (got_q[x] === e) n_pass++;
      else $display("FAIL mid_c[%0d]: got %0d expected %0d", x, $signed(got_q[x]), e);
    end
    exp_q.delete();
    n_total++; if (ident_after === 1'b1) n_pass++;
    else $display("FAIL mid_flag: got %b expected 1", ident_after);
  endtask

  task automatic test_min_value();
    logic signed [66:0] e;
    for (int x = 0; x < Elems; x++) begin
      ma[x] = 32'sd0;
      mb[x] = 32'sd0;
    end
    ma[0] = 32'sh8000_0000;
    mb[0] = 32'sh8000_0000;
    load_matrices();
    collect(-1, 0, 1'b0);
    n_total++; if (got_q.size() == Elems) n_pass++;
    else $display("FAIL min_count: got %0d expected %0d", got_q.size(), Elems);
    if (got_q.size() > 0) begin
      n_total++; if (got_q[0] === 67'sd4611686018427387904) n_pass++;
      else $display("FAIL min_c0: got %0d expected 4611686018427387904", $signed(got_q[0]));
    end
    for (int x = 0; x < got_q.size() && exp_q.size() > 0; x++) begin
      e = exp_q.pop_front();
      n_total++; if (got_q[x] === e) n_pass++;
      else $display("FAIL min_c[%0d]: got %0d expected %0d", x, $signed(got_q[x]), e);
    end
    exp_q.delete();
    n_total++; if (ident_after === 1'b0) n_pass++;
    else $display("FAIL min_flag: got %b expected 0", ident_after);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_identity();
    test_inverse_pair();
    test_non_identity();
    test_backpressure();
    test_reset_mid_op();
    test_min_value();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
